// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to TX and RX paths) and frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'b000,
    TX_START_BIT = 3'b001,
    TX_DATA_BITS = 3'b010,
    TX_STOP_BIT  = 3'b011,
    CLEANUP      = 3'b100
  } uart_state_t;

  localparam int unsigned DATA_BITS       = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO for the UART transmitter; full/empty from an occupancy count.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = DATA_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en;
  logic             rd_en;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign wr_en   = wr_valid && !full;
  assign rd_en   = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: FIFO-fed FSM serialising start, 8 data bits LSB first, stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  output logic                 o_TX_Ready,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Active,
  output logic                 o_TX_Done
);

  localparam int unsigned    CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t          state, state_next;
  logic [CW-1:0]        clk_count, clk_count_next;
  logic [2:0]           bit_index, bit_index_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 serial_next, active_next, done_next;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_empty;
  logic                 fifo_full;

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (DATA_BITS)
  ) u_fifo (
    .clk     (i_Clk),
    .rst_n   (i_Rst_n),
    .wr_valid(i_TX_DV),
    .wr_data (i_TX_Byte),
    .pop     (pop),
    .rd_data (fifo_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign o_TX_Ready = !fifo_full;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      clk_count   <= '0;
      bit_index   <= '0;
      shift       <= '0;
      o_TX_Serial <= UART_IDLE_LEVEL;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      state       <= state_next;
      clk_count   <= clk_count_next;
      bit_index   <= bit_index_next;
      shift       <= shift_next;
      o_TX_Serial <= serial_next;
      o_TX_Active <= active_next;
      o_TX_Done   <= done_next;
    end
  end

  always_comb begin
    state_next     = state;
    clk_count_next = clk_count;
    bit_index_next = bit_index;
    shift_next     = shift;
    pop            = 1'b0;
    case (state)
      IDLE: begin
        clk_count_next = '0;
        bit_index_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_data;
          state_next = TX_START_BIT;
        end
      end
      TX_START_BIT: begin
        if (clk_count == LAST_CLK) begin
          clk_count_next = '0;
          state_next     = TX_DATA_BITS;
        end else begin
          clk_count_next = clk_count + CW'(1);
        end
      end
      TX_DATA_BITS: begin
        if (clk_count == LAST_CLK) begin
          clk_count_next = '0;
          if (bit_index == LAST_BIT) begin
            bit_index_next = '0;
            state_next     = TX_STOP_BIT;
          end else begin
            bit_index_next = bit_index + 3'd1;
          end
        end else begin
          clk_count_next = clk_count + CW'(1);
        end
      end
      TX_STOP_BIT: begin
        if (clk_count == LAST_CLK) begin
          clk_count_next = '0;
          state_next     = CLEANUP;
        end else begin
          clk_count_next = clk_count + CW'(1);
        end
      end
      CLEANUP: begin
        clk_count_next = '0;
        state_next     = IDLE;
      end
      default: begin
        clk_count_next = '0;
        bit_index_next = '0;
        state_next     = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered line changes on the same edge as the FSM.
  always_comb begin
    serial_next = UART_IDLE_LEVEL;
    active_next = 1'b0;
    done_next   = 1'b0;
    case (state_next)
      TX_START_BIT: begin
        serial_next = ~UART_IDLE_LEVEL;
        active_next = 1'b1;
      end
      TX_DATA_BITS: begin
        serial_next = shift_next[bit_index_next];
        active_next = 1'b1;
      end
      TX_STOP_BIT: begin
        active_next = 1'b1;
      end
      CLEANUP: begin
        done_next = 1'b1;
      end
      default: begin
        serial_next = UART_IDLE_LEVEL;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: cycle-exact frame checks at CLKS_PER_BIT=4 plus 8N1 loopback at 217.
module tb_uart_tx;

  localparam int unsigned CPB_A = 4;
  localparam int unsigned CPB_B = 217;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dv_a, dv_b;
  logic [7:0] byte_a, byte_b;
  logic       ready_a, ser_a, act_a, done_a;
  logic       ready_b, ser_b, act_b, done_b;

  int total = 0;
  int bad   = 0;

  logic [8:0] q_a[$];
  logic [8:0] q_b[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(4)) dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_TX_DV(dv_a), .i_TX_Byte(byte_a),
    .o_TX_Ready(ready_a), .o_TX_Serial(ser_a), .o_TX_Active(act_a), .o_TX_Done(done_a)
  );

  uart_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(4)) dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_TX_DV(dv_b), .i_TX_Byte(byte_b),
    .o_TX_Ready(ready_b), .o_TX_Serial(ser_b), .o_TX_Active(act_b), .o_TX_Done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic line(input int sel);
    return (sel != 0) ? ser_b : ser_a;
  endfunction

  function automatic int qsize(input int sel);
    return (sel != 0) ? q_b.size() : q_a.size();
  endfunction

  // 8N1 receiver model: entered on the first low sample, samples each bit at its middle.
  task automatic rx_frame(input int sel, input int unsigned cpb, output logic [8:0] f);
    repeat (cpb / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(negedge clk);
      f[i] = line(sel);
    end
    repeat (cpb) @(negedge clk);
    f[8] = line(sel);
  endtask

  initial begin
    logic [8:0] f;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && ser_a === 1'b0) begin
        rx_frame(0, CPB_A, f);
        q_a.push_back(f);
      end
    end
  end

  initial begin
    logic [8:0] f;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && ser_b === 1'b0) begin
        rx_frame(1, CPB_B, f);
        q_b.push_back(f);
      end
    end
  end

  task automatic wait_q(input int sel, input int n, input int budget, input string tag);
    int cyc = 0;
    while (qsize(sel) < n && cyc < budget) begin
      tick;
      cyc++;
    end
    chk(tag, qsize(sel), n);
  endtask

  // Called at the sample point of the first start-bit cycle on dut_a.
  task automatic frame_check(input logic [7:0] b, input string tag);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10 * CPB_A; k++) begin
      chk({tag, "_ser"}, ser_a, fr[k / CPB_A]);
      chk({tag, "_act"}, act_a, 1);
      chk({tag, "_done_lo"}, done_a, 0);
      tick;
    end
    chk({tag, "_done_hi"}, done_a, 1);
    chk({tag, "_act_end"}, act_a, 0);
    chk({tag, "_ser_cln"}, ser_a, 1);
    tick;
    chk({tag, "_done_1cy"}, done_a, 0);
    chk({tag, "_ser_idle"}, ser_a, 1);
    chk({tag, "_act_idle"}, act_a, 0);
  endtask

  initial begin
    logic [7:0] lb [4];
    int act_seen;
    lb = '{8'h00, 8'hFF, 8'h3C, 8'h81};

    rst_n  = 1'b0;
    dv_a   = 1'b0;
    byte_a = '0;
    dv_b   = 1'b0;
    byte_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ser", ser_a, 1);
    chk("rst_act", act_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_ready", ready_a, 1);
    chk("rst_ser_b", ser_b, 1);
    chk("rst_act_b", act_b, 0);
    chk("rst_done_b", done_b, 0);
    rst_n = 1'b1;
    tick;

    // Single byte with one-cycle pop latency
    chk("single_ready", ready_a, 1);
    dv_a   = 1'b1;
    byte_a = 8'h55;
    tick;
    dv_a = 1'b0;
    chk("lat_ser_hi", ser_a, 1);
    chk("lat_act_lo", act_a, 0);
    tick;
    frame_check(8'h55, "single");

    // Back-to-back: exactly two idle-high cycles after the stop bit
    dv_a   = 1'b1;
    byte_a = 8'hA5;
    tick;
    byte_a = 8'h3C;
    tick;
    dv_a = 1'b0;
    frame_check(8'hA5, "b2b_a5");
    tick;
    frame_check(8'h3C, "b2b_3c");

    // Full FIFO: 0x06 is dropped
    q_a.delete();
    for (int i = 1; i <= 6; i++) begin
      byte_a = 8'(i);
      dv_a   = 1'b1;
      chk("full_ready_pre", ready_a, (i <= 5) ? 1 : 0);
      tick;
    end
    dv_a = 1'b0;
    chk("full_ready_lo", ready_a, 0);
    chk("full_busy", act_a, 1);
    wait_q(0, 5, 300, "full_count");
    for (int i = 0; i < 5; i++) begin
      chk("full_byte", q_a[i], {1'b1, 8'(i + 1)});
    end
    repeat (100) tick;
    chk("full_no_extra", q_a.size(), 5);
    chk("full_ready_back", ready_a, 1);

    // Reset during data bit 3 of 0xFF with another byte still queued
    q_a.delete();
    dv_a   = 1'b1;
    byte_a = 8'hFF;
    tick;
    byte_a = 8'h12;
    tick;
    dv_a = 1'b0;
    chk("rst_mid_start", act_a, 1);
    repeat (17) tick;
    chk("rst_mid_bit3", ser_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ser", ser_a, 1);
    chk("rst_async_act", act_a, 0);
    chk("rst_async_ready", ready_a, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_rel_act", act_a, 0);
    chk("rst_rel_ready", ready_a, 1);
    chk("rst_rel_ser", ser_a, 1);
    act_seen = 0;
    for (int i = 0; i < 120; i++) begin
      tick;
      if (act_a !== 1'b0) act_seen++;
      if (i == 60) q_a.delete();
    end
    chk("rst_quiet_act", act_seen, 0);
    chk("rst_quiet_rx", q_a.size(), 0);

    // Loopback at CLKS_PER_BIT=217
    for (int i = 0; i < 4; i++) begin
      dv_b   = 1'b1;
      byte_b = lb[i];
      chk("lb_ready", ready_b, 1);
      tick;
    end
    dv_b = 1'b0;
    wait_q(1, 4, 4 * (10 * CPB_B + 2) + 300, "lb_count");
    for (int i = 0; i < 4; i++) begin
      chk("lb_byte", q_b[i][7:0], lb[i]);
      chk("lb_stop", q_b[i][8], 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
